// File: rtl/alu_control_seq.sv
// ALU control decoder with registered outputs and a valid strobe; multi-cycle
// mult/div ops issue a start pulse and stall upstream for a fixed latency.
module alu_control_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        aluOp,
  input  logic [5:0]        funct,
  output logic              out_valid,
  output logic [CTRL_W-1:0] aluControl,
  output logic              undef,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              stall
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CTRL_W-1:0] CODE_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CODE_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CODE_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CODE_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CODE_XOR  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] CODE_NOR  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] CODE_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] CODE_SLTU = CTRL_W'(4'b1111);
  localparam logic [CTRL_W-1:0] CODE_SLL  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] CODE_SRL  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] CODE_SRA  = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] CODE_MD   = CTRL_W'(4'b1101);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] alu_control_q, alu_control_d;
  logic              undef_q, undef_d;
  logic              md_start_q, md_start_d;
  logic [1:0]        md_op_q, md_op_d;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_undef;
  logic              dec_md;

  // Undefined ops fall back to the safe add code so the output is never x.
  always_comb begin
    dec_code  = CODE_ADD;
    dec_undef = 1'b0;
    dec_md    = 1'b0;
    case (aluOp)
      3'b000: dec_code = CODE_ADD;
      3'b001: dec_code = CODE_SUB;
      3'b010, 3'b011: begin
        case (funct)
          6'd32: dec_code = CODE_ADD;
          6'd34: dec_code = CODE_SUB;
          6'd36: dec_code = CODE_AND;
          6'd37: dec_code = CODE_OR;
          6'd38: dec_code = CODE_XOR;
          6'd39: dec_code = CODE_NOR;
          6'd42: dec_code = CODE_SLT;
          6'd43: dec_code = CODE_SLTU;
          6'd0:  dec_code = CODE_SLL;
          6'd2:  dec_code = CODE_SRL;
          6'd3:  dec_code = CODE_SRA;
          6'd24, 6'd25, 6'd26, 6'd27: begin
            dec_code = CODE_MD;
            dec_md   = 1'b1;
          end
          default: dec_undef = 1'b1;
        endcase
      end
      3'b100: dec_code = CODE_AND;
      3'b101: dec_code = CODE_OR;
      3'b110: dec_code = CODE_SLT;
      default: dec_undef = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = 1'b0;
    md_start_d    = 1'b0;
    alu_control_d = alu_control_q;
    undef_d       = undef_q;
    md_op_d       = md_op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_md) begin
            // funct 24..27 map directly onto md_op via their low two bits.
            state_d    = BUSY;
            md_start_d = 1'b1;
            md_op_d    = funct[1:0];
            cnt_d      = funct[1] ? DIV_LOAD : MUL_LOAD;
          end else begin
            out_valid_d   = 1'b1;
            alu_control_d = dec_code;
            undef_d       = dec_undef;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          alu_control_d = CODE_MD;
          undef_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      alu_control_q <= '0;
      undef_q       <= 1'b0;
      md_start_q    <= 1'b0;
      md_op_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      alu_control_q <= alu_control_d;
      undef_q       <= undef_d;
      md_start_q    <= md_start_d;
      md_op_q       <= md_op_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign aluControl = alu_control_q;
  assign undef      = undef_q;
  assign md_start   = md_start_q;
  assign md_op      = md_op_q;
  assign stall      = (state_q == BUSY);

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq; a second instance with
// MUL_LAT=1 covers the minimum-latency corner.
module tb_alu_control_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_valid1;
  logic [2:0] aluOp;
  logic [5:0] funct;

  logic       out_valid, undef, md_start, stall;
  logic [3:0] aluControl;
  logic [1:0] md_op;
  logic       out_valid1, undef1, md_start1, stall1;
  logic [3:0] aluControl1;
  logic [1:0] md_op1;

  // Packed view: {out_valid, undef, md_start, stall, md_op[1:0], aluControl[3:0]}
  logic [9:0] obs, obs1;
  assign obs  = {out_valid, undef, md_start, stall, md_op, aluControl};
  assign obs1 = {out_valid1, undef1, md_start1, stall1, md_op1, aluControl1};

  int checks;
  int failures;

  alu_control_seq #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluOp(aluOp), .funct(funct),
    .out_valid(out_valid), .aluControl(aluControl), .undef(undef),
    .md_start(md_start), .md_op(md_op), .stall(stall)
  );

  alu_control_seq #(.CTRL_W(4), .MUL_LAT(1), .DIV_LAT(2), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .aluOp(aluOp), .funct(funct),
    .out_valid(out_valid1), .aluControl(aluControl1), .undef(undef1),
    .md_start(md_start1), .md_op(md_op1), .stall(stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; aluOp = 3'b000; funct = 6'd0;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_initial obs=%b expected=%b", obs, 10'b0);
    end
    tick; tick;
    rst = 1'b0;
    in_valid = 1'b1; aluOp = 3'b000;
    tick;
    checks++;
    if (obs !== 10'b1000000010) begin
      failures++;
      $display("[TB] FAIL reset_first_add obs=%b expected=%b", obs, 10'b1000000010);
    end
    aluOp = 3'b010; funct = 6'd0;
    tick;
    checks++;
    if (obs !== 10'b1000001000) begin
      failures++;
      $display("[TB] FAIL reset_pre_sll obs=%b expected=%b", obs, 10'b1000001000);
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_async obs=%b expected=%b", obs, 10'b0);
    end
    #1 rst = 1'b0;
    tick;
  endtask

  task automatic test_rtype_sweep;
    logic [5:0] f [11];
    logic [3:0] e [11];
    f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd0, 6'd2, 6'd3};
    e = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100,
          4'b0111, 4'b1111, 4'b1000, 4'b1001, 4'b1010};
    in_valid = 1'b1; aluOp = 3'b010;
    for (int i = 0; i < 11; i++) begin
      funct = f[i];
      tick;
      checks++;
      if (obs !== {6'b100000, e[i]}) begin
        failures++;
        $display("[TB] FAIL rtype_funct%0d obs=%b expected=%b", f[i], obs, {6'b100000, e[i]});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_undefined;
    in_valid = 1'b1; aluOp = 3'b010; funct = 6'd63;
    tick;
    checks++;
    if (obs !== 10'b1100000010) begin
      failures++;
      $display("[TB] FAIL undef_funct63 obs=%b expected=%b", obs, 10'b1100000010);
    end
    aluOp = 3'b010; funct = 6'd34;
    tick;
    checks++;
    if (obs !== 10'b1000000110) begin
      failures++;
      $display("[TB] FAIL undef_clear obs=%b expected=%b", obs, 10'b1000000110);
    end
    aluOp = 3'b111;
    tick;
    checks++;
    if (obs !== 10'b1100000010) begin
      failures++;
      $display("[TB] FAIL undef_aluop111 obs=%b expected=%b", obs, 10'b1100000010);
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (obs !== 10'b0100000010) begin
      failures++;
      $display("[TB] FAIL idle_hold obs=%b expected=%b", obs, 10'b0100000010);
    end
  endtask

  task automatic test_mult;
    in_valid = 1'b1; aluOp = 3'b010; funct = 6'd24;
    tick;
    checks++;
    if (obs !== 10'b0111000010) begin
      failures++;
      $display("[TB] FAIL mult_start obs=%b expected=%b", obs, 10'b0111000010);
    end
    aluOp = 3'b001;
    for (int k = 2; k <= 4; k++) begin
      tick;
      checks++;
      if (obs !== 10'b0101000010) begin
        failures++;
        $display("[TB] FAIL mult_stall_c%0d obs=%b expected=%b", k, obs, 10'b0101000010);
      end
    end
    tick;
    checks++;
    if (obs !== 10'b1000001101) begin
      failures++;
      $display("[TB] FAIL mult_done obs=%b expected=%b", obs, 10'b1000001101);
    end
    tick;
    checks++;
    if (obs !== 10'b1000000110) begin
      failures++;
      $display("[TB] FAIL mult_followon_sub obs=%b expected=%b", obs, 10'b1000000110);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_div_and_reset;
    in_valid = 1'b1; aluOp = 3'b011; funct = 6'd27;
    tick;
    checks++;
    if (obs !== 10'b0011110110) begin
      failures++;
      $display("[TB] FAIL divu_start obs=%b expected=%b", obs, 10'b0011110110);
    end
    in_valid = 1'b0;
    for (int k = 2; k <= 32; k++) begin
      tick;
      checks++;
      if (obs !== 10'b0001110110) begin
        failures++;
        $display("[TB] FAIL divu_stall_c%0d obs=%b expected=%b", k, obs, 10'b0001110110);
      end
    end
    tick;
    checks++;
    if (obs !== 10'b1000111101) begin
      failures++;
      $display("[TB] FAIL divu_done obs=%b expected=%b", obs, 10'b1000111101);
    end
    in_valid = 1'b1; funct = 6'd26;
    tick;
    checks++;
    if (obs !== 10'b0011101101) begin
      failures++;
      $display("[TB] FAIL div_start obs=%b expected=%b", obs, 10'b0011101101);
    end
    in_valid = 1'b0;
    for (int k = 2; k <= 10; k++) tick;
    checks++;
    if (obs !== 10'b0001101101) begin
      failures++;
      $display("[TB] FAIL div_stall_c10 obs=%b expected=%b", obs, 10'b0001101101);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      failures++;
      $display("[TB] FAIL div_reset_async obs=%b expected=%b", obs, 10'b0);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      checks++;
      if (obs !== 10'b0) begin
        failures++;
        $display("[TB] FAIL div_dropped_c%0d obs=%b expected=%b", k, obs, 10'b0);
      end
    end
    in_valid = 1'b1; aluOp = 3'b101;
    tick;
    checks++;
    if (obs !== 10'b1000000001) begin
      failures++;
      $display("[TB] FAIL post_reset_or obs=%b expected=%b", obs, 10'b1000000001);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_latency_one;
    in_valid1 = 1'b1; aluOp = 3'b011; funct = 6'd25;
    tick;
    checks++;
    if (obs1 !== 10'b0011010000) begin
      failures++;
      $display("[TB] FAIL lat1_start obs=%b expected=%b", obs1, 10'b0011010000);
    end
    in_valid1 = 1'b0;
    tick;
    checks++;
    if (obs1 !== 10'b1000011101) begin
      failures++;
      $display("[TB] FAIL lat1_done obs=%b expected=%b", obs1, 10'b1000011101);
    end
    tick;
    checks++;
    if (obs1 !== 10'b0000011101) begin
      failures++;
      $display("[TB] FAIL lat1_idle obs=%b expected=%b", obs1, 10'b0000011101);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_rtype_sweep;
    test_undefined;
    test_mult;
    test_div_and_reset;
    test_latency_one;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder in the MIPS core.
- Decodes aluOp/funct into a CTRL_W-bit ALU control code with a registered output and an explicit valid strobe.
- Extends coverage to xor/nor/sltu/shifts and I-type logical ops.
- Sequences multi-cycle mult/div ops: issues a start pulse to the mul/div unit and holds a pipeline stall for a parametrised latency.

Parameters:
CTRL_W, 4, width of aluControl (≥4)
MUL_LAT, 4, cycles the mul/div unit needs for mult/multu (≥1)
DIV_LAT, 32, cycles for div/divu (≥1)
CNT_W, 6, latency counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  aluOp/funct valid this cycle
aluOp  in  3  main-decoder op class
funct  in  6  R-type funct field
out_valid  out  1  aluControl valid (one-cycle strobe per accepted op)
aluControl  out  CTRL_W  ALU control code
undef  out  1  accepted op was undefined (qualified by out_valid)
md_start  out  1  one-cycle start pulse to mul/div unit
md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held while busy
stall  out  1  upstream must hold instruction; in_valid ignored

Behaviour:
- Reset: all outputs 0 (aluControl=0, md_op=00), state IDLE, counter 0. Takes effect immediately, including mid-BUSY: the pending op is dropped and no out_valid is produced.
- aluOp decode:
  - 000 add
  - 001 sub
  - 01x R-type via funct
  - 100 and
  - 101 or
  - 110 slt
  - 111 undefined
- funct decode (codes zero-extended to CTRL_W):
  - 32 add 0010; 34 sub 0110; 36 and 0000; 37 or 0001; 38 xor 0011; 39 nor 1100
  - 42 slt 0111; 43 sltu 1111; 0 sll 1000; 2 srl 1001; 3 sra 1010
  - 24 mult, 25 multu, 26 div, 27 divu → multi-cycle, code 1101
  - any other funct → undefined
- Undefined op: aluControl=0010 (safe add), undef=1, single-cycle. Never drive x.
- States: IDLE, BUSY.
- IDLE, in_valid=1, single-cycle op accepted at edge T:
  - Next cycle: out_valid=1, aluControl/undef updated.
  - Latency 1; back-to-back accepts every cycle.
- IDLE, in_valid=1, multi-cycle op accepted at edge T:
  - Next cycle: md_start=1 (exactly one cycle), md_op set, stall=1, state BUSY.
  - Counter loads LAT-1 (MUL_LAT for mult/multu, DIV_LAT for div/divu).
  - out_valid=0 in that cycle.
- BUSY:
  - stall=1; in_valid ignored; counter decrements each cycle.
  - When the counter is 0 at an edge: next cycle out_valid=1, aluControl=1101, undef=0, stall=0, state IDLE.
  - Net timing: stall is high for exactly LAT cycles; out_valid arrives LAT+1 cycles after acceptance.
- In the cycle out_valid completes a multi-cycle op, the FSM is IDLE and accepts in_valid normally.
- IDLE, in_valid=0: out_valid=0, md_start=0. aluControl/undef/md_op hold their last values.
- aluControl only changes on an accepting edge or on completion.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 asynchronously; release, in_valid with aluOp=000 → next cycle out_valid=1, aluControl=0010.
- R-type sweep: aluOp=010, funct 32,34,36,37,38,39,42,43,0,2,3 back-to-back → one cycle later each: 0010,0110,0000,0001,0011,1100,0111,1111,1000,1001,1010, out_valid high continuously, undef=0.
- Undefined: aluOp=010 funct=63, then aluOp=111 → each gives out_valid=1, undef=1, aluControl=0010.
- Mult, MUL_LAT=4: accept funct=24 at T → md_start=1 at T+1 only, md_op=00, stall=1 for T+1..T+4, out_valid=1 with aluControl=1101 at T+5. in_valid with aluOp=001 held during stall is ignored until T+5, then yields 0110 at T+6.
- Div, DIV_LAT=32 plus reset mid-op: accept funct=27 → md_op=11, stall for 32 cycles, out_valid on the 33rd. Repeat with rst at cycle 10 → stall drops immediately, no out_valid, next op accepted normally.
- Latency-1 corner: MUL_LAT=1, accept funct=25 → stall=1 for exactly one cycle, out_valid 2 cycles after acceptance.
